bcd_conv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one binary-to-BCD converter between two requesters in the Fibonacci display path. Typically requester 0 is the Fibonacci result and requester 1 is the index/status counter. Each requester posts a one-cycle request with a binary value. The block buffers the request, then issues the converter start handshake. It captures the 4-digit BCD result into a per-requester holding register and acknowledges the owner. A watchdog aborts a conversion if the converter never completes.

---
 rtl/bcd_conv_arbiter.sv | 127 ++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one binary-to-BCD converter between two requesters.
// It keeps a holding register per requester and a watchdog for conversions that never finish.
module bcd_conv_arbiter #(
    parameter int BIN_W = 15,
    parameter int TO_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [BIN_W-1:0] bin0,
    input  logic             req1,
    input  logic [BIN_W-1:0] bin1,
    output logic             ack0,
    output logic             ack1,
    output logic             err,
    output logic [15:0]      res0,
    output logic [15:0]      res1,
    output logic             busy,
    output logic             cv_start,
    output logic [BIN_W-1:0] cv_bin,
    input  logic             cv_ready,
    input  logic             cv_done_tick,
    input  logic [15:0]      cv_bcd
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] BUSY    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam logic [TO_W-1:0] WD_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic             pend0_q, pend1_q;
    logic [BIN_W-1:0] hold0_q, hold1_q;
    logic             last_q, owner_q;
    logic [TO_W-1:0]  wdog_q;
    logic             done_prev_q;
    logic [15:0]      bcd_q;

    logic grant0, grant1, done_edge, timeout, finish;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && cv_ready) begin
            grant0 = pend0_q && (!pend1_q || last_q);
            grant1 = pend1_q && (!pend0_q || !last_q);
        end
    end

    // A done edge in the terminal-count cycle beats the timeout.
    always_comb begin
        done_edge = cv_done_tick && !done_prev_q;
        timeout   = (state_q == BUSY) && !done_edge && (wdog_q == '1);
        finish    = (state_q == CAPTURE) || timeout;
        ack0      = finish && !owner_q;
        ack1      = finish && owner_q;
        err       = timeout;
        busy      = (state_q != IDLE);
        cv_start  = (state_q == ISSUE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant0 || grant1) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY: begin
                if (done_edge)    state_d = CAPTURE;
                else if (timeout) state_d = RELEASE;
            end
            CAPTURE: state_d = RELEASE;
            RELEASE: if (cv_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend0_q     <= 1'b0;
            pend1_q     <= 1'b0;
            hold0_q     <= '0;
            hold1_q     <= '0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            wdog_q      <= '0;
            done_prev_q <= 1'b0;
            bcd_q       <= '0;
            cv_bin      <= '0;
            res0        <= '0;
            res1        <= '0;
        end else begin
            state_q <= state_d;
            if (req0) hold0_q <= bin0;
            if (req1) hold1_q <= bin1;
            // A request in the grant cycle re-arms the buffer; the granted operand is already latched.
            pend0_q <= grant0 ? req0 : (pend0_q | req0);
            pend1_q <= grant1 ? req1 : (pend1_q | req1);
            if (grant0 || grant1) begin
                owner_q <= grant1;
                last_q  <= grant1;
                cv_bin  <= grant1 ? hold1_q : hold0_q;
            end
            case (state_q)
                ISSUE: begin
                    wdog_q      <= '0;
                    done_prev_q <= 1'b0;
                end
                BUSY: begin
                    if (wdog_q != '1) wdog_q <= wdog_q + WD_ONE;
                    done_prev_q <= cv_done_tick;
                    if (done_edge) bcd_q <= cv_bcd;
                end
                CAPTURE: begin
                    if (owner_q) res1 <= bcd_q;
                    else         res0 <= bcd_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: converter model, arbitration scoreboard,
// and a second instance with a short watchdog for the timeout cases.
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [14:0] bin0, bin1;
    logic        ack0, ack1, err, busy, cv_start;
    logic [15:0] res0, res1, cv_bcd;
    logic [14:0] cv_bin;
    logic        cv_ready, cv_done_tick;

    logic        req0_4, req1_4;
    logic [14:0] bin0_4, bin1_4;
    logic        ack0_4, ack1_4, err_4, busy_4, cv_start_4;
    logic [15:0] res0_4, res1_4, bcd_4;
    logic [14:0] cv_bin_4;
    logic        cv_ready_4, done_4;

    bcd_conv_arbiter #(.BIN_W(15), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
        .ack0(ack0), .ack1(ack1), .err(err), .res0(res0), .res1(res1), .busy(busy),
        .cv_start(cv_start), .cv_bin(cv_bin), .cv_ready(cv_ready),
        .cv_done_tick(cv_done_tick), .cv_bcd(cv_bcd)
    );

    bcd_conv_arbiter #(.BIN_W(15), .TO_W(4)) dut4 (
        .clk(clk), .reset(reset), .req0(req0_4), .bin0(bin0_4), .req1(req1_4), .bin1(bin1_4),
        .ack0(ack0_4), .ack1(ack1_4), .err(err_4), .res0(res0_4), .res1(res1_4), .busy(busy_4),
        .cv_start(cv_start_4), .cv_bin(cv_bin_4), .cv_ready(cv_ready_4),
        .cv_done_tick(done_4), .cv_bcd(bcd_4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending flags, latest operands, round-robin pointer.
    bit          mpend [2];
    int          mhold [2];
    int          mlast;
    int          exp_owner[$];
    int          exp_val[$];
    logic [15:0] exp_res [2];
    int          ack_log[$];
    int          starts, acks;
    bit          res_pending, err_seen;
    int          lat = 16, dlen = 3, done_rise_cyc = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flush_model();
        mpend[0] = 0; mpend[1] = 0; mlast = 1;
        exp_owner.delete(); exp_val.delete(); ack_log.delete();
        exp_res[0] = '0; exp_res[1] = '0;
        starts = 0; acks = 0; res_pending = 0;
    endtask

    // Caller sits at a negedge; requests are live for exactly one cycle.
    task automatic post(input bit r0, input int v0, input bit r1, input int v1);
        req0 = r0; bin0 = 15'(v0);
        req1 = r1; bin1 = 15'(v1);
        if (r0) begin mpend[0] = 1; mhold[0] = v0; end
        if (r1) begin mpend[1] = 1; mhold[1] = v1; end
        @(negedge clk);
        req0 = 0; req1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        flush_model();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic wait_ack(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ack0 || ack1) break;
        end
        check("ack_in_budget", k < budget, 1);
    endtask

    task automatic wait_start(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (cv_start) break;
        end
        check("start_in_budget", k < budget, 1);
    endtask

    task automatic wait_quiet(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy && !mpend[0] && !mpend[1] && !res_pending && cv_ready) break;
        end
        check("quiet_in_budget", k < budget, 1);
    endtask

    // Converter model: ready drops on start, done rises after lat cycles and stays for dlen.
    initial begin
        int phase, cnt, dcnt;
        logic [14:0] cval;
        phase = 0; cnt = 0; dcnt = 0; cval = '0;
        cv_ready = 1; cv_done_tick = 0; cv_bcd = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                phase = 0; cv_ready = 1; cv_done_tick = 0;
            end else if (phase == 0) begin
                if (cv_start) begin cval = cv_bin; cv_ready = 0; cnt = lat; phase = 1; end
            end else if (phase == 1) begin
                cnt--;
                if (cnt == 0) begin
                    cv_done_tick = 1; cv_bcd = to_bcd(int'(cval));
                    done_rise_cyc = cyc; dcnt = dlen; phase = 2;
                end
            end else begin
                dcnt--;
                if (dcnt == 0) begin cv_done_tick = 0; cv_ready = 1; phase = 0; end
            end
        end
    end

    // Scoreboard: predicts each grant and checks each ack and the result it leaves behind.
    initial begin
        int g, n;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                res_pending = 0;
            end else begin
                if (res_pending) begin
                    check("res0_value", res0, exp_res[0]);
                    check("res1_value", res1, exp_res[1]);
                    res_pending = 0;
                end
                if (err) err_seen = 1;
                if (cv_start) begin
                    starts++;
                    check("start_when_ready", cv_ready, 1);
                    check("start_has_pending", mpend[0] | mpend[1], 1);
                    if (mpend[0] && mpend[1]) g = 1 - mlast;
                    else if (mpend[0])        g = 0;
                    else                      g = 1;
                    if (mpend[g]) begin
                        check("grant_operand", cv_bin, mhold[g]);
                        mpend[g] = 0; mlast = g;
                        exp_owner.push_back(g); exp_val.push_back(mhold[g]);
                    end
                end
                if (ack0 || ack1) begin
                    acks++;
                    n = ack1 ? 1 : 0;
                    check("ack_both", ack0 & ack1, 0);
                    check("ack_err", err, 0);
                    check("ack_latency", cyc, done_rise_cyc + 1);
                    check("ack_outstanding", exp_owner.size(), 1);
                    if (exp_owner.size() > 0) begin
                        check("ack_owner", n, exp_owner[0]);
                        exp_res[n] = to_bcd(exp_val[0]);
                        void'(exp_owner.pop_front());
                        void'(exp_val.pop_front());
                        ack_log.push_back(n);
                        res_pending = 1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int r0, r1, v0, v1, a_before;
        reset = 1; req0 = 0; req1 = 0; bin0 = '0; bin1 = '0;
        req0_4 = 0; req1_4 = 0; bin0_4 = '0; bin1_4 = '0;
        cv_ready_4 = 1; done_4 = 0; bcd_4 = 16'h4321;
        err_seen = 0;
        flush_model();
        repeat (3) @(negedge clk);

        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_err", err, 0);
        check("rst_res0", res0, 16'h0000);
        check("rst_res1", res1, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_cv_start", cv_start, 0);
        check("rst_cv_bin", cv_bin, 0);
        reset = 0;
        @(negedge clk);

        // Single conversion with request-to-start timing.
        post(1, 1234, 0, 0);
        check("t1_idle", busy, 0);
        check("t1_no_start", cv_start, 0);
        @(negedge clk);
        check("t2_start", cv_start, 1);
        check("t2_cv_bin", cv_bin, 1234);
        wait_quiet(200);
        check("single_res0", res0, 16'h1234);
        check("single_res1", res1, 16'h0000);
        check("single_acks", acks, 1);

        // Simultaneous requests right after reset: requester 0 wins the tie.
        do_reset();
        post(1, 42, 1, 9999);
        wait_quiet(400);
        check("sim_res0", res0, 16'h0042);
        check("sim_res1", res1, 16'h9999);
        check("sim_nacks", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            check("sim_first", ack_log[0], 0);
            check("sim_second", ack_log[1], 1);
        end
        check("sim_starts", starts, 2);

        // Fairness: both re-request on every ack.
        do_reset();
        post(1, $urandom_range(9999), 1, $urandom_range(9999));
        for (int i = 0; i < 4; i++) begin
            wait_ack(200);
            post(1, $urandom_range(9999), 1, $urandom_range(9999));
        end
        wait_quiet(600);
        check("fair_count", ack_log.size(), 6);
        if (ack_log.size() == 6) begin
            check("fair_first", ack_log[0], 0);
            for (int i = 1; i < 6; i++) check("fair_alternate", ack_log[i] != ack_log[i-1], 1);
        end

        // Overwrite while pending.
        do_reset();
        post(1, $urandom_range(9999), 0, 0);
        wait_start(20);
        @(negedge clk);
        post(0, 0, 1, 5);
        repeat (3) @(negedge clk);
        post(0, 0, 1, 77);
        wait_quiet(400);
        check("ovr_res1", res1, 16'h0077);
        check("ovr_nacks", ack_log.size(), 2);
        check("ovr_starts", starts, 2);

        // Long done/ready-low interval, with a request waiting behind it.
        do_reset();
        dlen = 500;
        post(1, $urandom_range(9999), 0, 0);
        wait_ack(100);
        repeat (10) @(negedge clk);
        check("long_busy_release", busy, 1);
        post(0, 0, 1, $urandom_range(9999));
        repeat (20) @(negedge clk);
        check("long_no_restart", starts, 1);
        wait_quiet(1500);
        dlen = 3;
        check("long_nacks", ack_log.size(), 2);
        check("long_starts", starts, 2);

        // Reset in the middle of BUSY.
        do_reset();
        post(1, $urandom_range(9999, 1), 0, 0);
        wait_quiet(200);
        post(1, $urandom_range(9999), 0, 0);
        wait_start(20);
        repeat (5) @(negedge clk);
        reset = 1;
        flush_model();
        #1;
        check("mid_ack0", ack0, 0);
        check("mid_ack1", ack1, 0);
        check("mid_err", err, 0);
        check("mid_res0", res0, 16'h0000);
        check("mid_res1", res1, 16'h0000);
        check("mid_busy", busy, 0);
        check("mid_cv_start", cv_start, 0);
        check("mid_cv_bin", cv_bin, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        a_before = acks;
        repeat (40) @(negedge clk);
        check("mid_no_ack", acks, a_before);
        post(1, $urandom_range(9999), 0, 0);
        wait_quiet(200);
        check("mid_recover_acks", acks, a_before + 1);

        // Random traffic, sometimes with a second request mid-conversion.
        for (int it = 0; it < 6; it++) begin
            r0 = int'($urandom_range(1));
            r1 = (r0 != 0) ? int'($urandom_range(1)) : 1;
            v0 = int'($urandom_range(9999));
            v1 = int'($urandom_range(9999));
            post(r0 != 0, v0, r1 != 0, v1);
            wait_start(20);
            @(negedge clk);
            if ($urandom_range(1) == 1)
                post($urandom_range(1) == 1, $urandom_range(9999), 1, $urandom_range(9999));
            wait_quiet(400);
        end
        check("rand_balance", starts, acks);
        check("err_never", err_seen, 0);

        // Short watchdog: a converter that never finishes.
        @(negedge clk);
        req0_4 = 1; bin0_4 = 15'd123;
        @(negedge clk);
        req0_4 = 0;
        @(negedge clk);
        check("to_start", cv_start_4, 1);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("to_no_early_ack", ack0_4, 0);
        end
        @(negedge clk);
        check("to_ack0", ack0_4, 1);
        check("to_err", err_4, 1);
        check("to_ack1", ack1_4, 0);
        check("to_res0", res0_4, 16'h0000);
        @(negedge clk);
        check("to_single_ack", ack0_4, 0);
        check("to_release", busy_4, 1);
        @(negedge clk);
        check("to_idle", busy_4, 0);

        // Done edge exactly at terminal count: done wins.
        req0_4 = 1; bin0_4 = 15'd7;
        @(negedge clk);
        req0_4 = 0;
        @(negedge clk);
        check("tie_start", cv_start_4, 1);
        check("tie_cv_bin", cv_bin_4, 7);
        repeat (15) @(negedge clk);
        @(negedge clk);
        done_4 = 1;
        #1;
        check("tie_no_timeout_ack", ack0_4, 0);
        check("tie_no_err", err_4, 0);
        @(negedge clk);
        check("tie_ack0", ack0_4, 1);
        check("tie_err", err_4, 0);
        @(negedge clk);
        check("tie_res0", res0_4, 16'h4321);
        check("tie_res1", res1_4, 16'h0000);
        done_4 = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
